// File: rtl/debounce_pkg.sv
// debounce_pkg: shared definitions for the key debouncer channels.
// Holds the per-channel FSM state encoding and a counter width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } db_state_e;

  // Bits needed to count 0 .. max_count-1, never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one debounced key channel.
// raw -> optional inversion -> 2-FF sync -> DEPTH-sample window -> stable level,
// plus an IDLE/HOLD/LONG FSM producing press, release, long-press and repeat pulses.
// Macro KEY_DEBOUNCE_AUTOREPEAT_EN: when defined, the LONG state emits repeat pulses;
// when undefined, no repeat counter exists and rep_pulse is tied low.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LONG_CNT   = 100,
  parameter int REP_CNT    = 20,
  parameter bit LEVEL_ONLY = 1'b0,
  parameter bit INV        = 1'b0
) (
  input  logic clk_db,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic rel_pulse,
  output logic long_pulse,
  output logic rep_pulse
);

  localparam int                HOLD_W    = cnt_width(LONG_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  // A switch channel, or one configured with out-of-range counts, behaves as level-only.
  localparam bit FSM_EN = !LEVEL_ONLY && (DEPTH >= 2) && (LONG_CNT >= 2) && (REP_CNT >= 2);

  logic             sync_a;
  logic             sync_b;
  logic [DEPTH-1:0] shift;
  logic             stable;
  logic             all_ones;
  logic             all_zeros;
  logic             rise;
  logic             fall;

  db_state_e         state;
  db_state_e         state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              press_nxt;
  logic              rel_nxt;
  logic              long_nxt;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int               REP_W    = cnt_width(REP_CNT);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CNT - 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_nxt;
  logic             rep_nxt;
`endif

  // Bring the asynchronous pin into clk_db and keep the last DEPTH synchronised samples.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      shift  <= '0;
    end else begin
      sync_a <= raw ^ INV;
      sync_b <= sync_a;
      shift  <= {shift[DEPTH-2:0], sync_b};
    end
  end

  assign all_ones  = &shift;
  assign all_zeros = ~|shift;
  assign rise      = all_ones & ~stable;
  assign fall      = all_zeros & stable;

  // The level only moves once the whole window agrees; mixed windows hold the old level.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      stable <= 1'b0;
    end else if (all_ones) begin
      stable <= 1'b1;
    end else if (all_zeros) begin
      stable <= 1'b0;
    end
  end

  assign level = stable;

  // Next-state logic; a release wins over any long or repeat event in the same cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    rep_cnt_nxt = rep_cnt;
    rep_nxt     = 1'b0;
`endif
    if (!FSM_EN) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rep_cnt_nxt = '0;
`endif
    end else if (fall) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
      rel_nxt   = 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rep_cnt_nxt = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = ST_LONG;
            hold_nxt  = '0;
            long_nxt  = 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rep_cnt_nxt = '0;
`endif
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        ST_LONG: begin
          state_nxt = ST_LONG;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          if (rep_cnt == REP_LAST) begin
            rep_cnt_nxt = '0;
            rep_nxt     = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
`endif
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Register state, counters and pulses so pulses line up with the level change.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      press_pulse <= 1'b0;
      rel_pulse   <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      press_pulse <= press_nxt;
      rel_pulse   <= rel_nxt;
      long_pulse  <= long_nxt;
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  // Repeat interval counter and its pulse, only present with auto-repeat enabled.
  always_ff @(posedge clk_db) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_pulse <= rep_nxt;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N_CH independent key/switch debouncers on the 100 Hz clk_db tick.
// Each bit of LEVEL_MASK turns a channel into a pulse-free switch input; each bit of
// INV_MASK marks an active-low pin. Auto-repeat is enabled by KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_multi
  import debounce_pkg::*;
#(
  parameter int              N_CH       = 8,
  parameter int              DEPTH      = 3,
  parameter int              LONG_CNT   = 100,
  parameter int              REP_CNT    = 20,
  parameter logic [N_CH-1:0] LEVEL_MASK = {N_CH{1'b0}},
  parameter logic [N_CH-1:0] INV_MASK   = {N_CH{1'b0}}
) (
  input  logic            clk_db,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] rel_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] rep_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEPTH      (DEPTH),
      .LONG_CNT   (LONG_CNT),
      .REP_CNT    (REP_CNT),
      .LEVEL_ONLY (LEVEL_MASK[i]),
      .INV        (INV_MASK[i])
    ) u_ch (
      .clk_db      (clk_db),
      .rst         (rst),
      .raw         (raw_i[i]),
      .level       (level_o[i]),
      .press_pulse (press_o[i]),
      .rel_pulse   (rel_o[i]),
      .long_pulse  (long_o[i]),
      .rep_pulse   (rep_o[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: self-checking bench for key_debounce_multi.
// Two instances share the pins: dut_a has channel 7 as a level-only switch, dut_b has none;
// both have channel 3 active-low. A timing-rule reference model predicts every output.
// Honours KEY_DEBOUNCE_AUTOREPEAT_EN the same way as the design.
module tb_key_debounce_multi;

  localparam int              N_CH     = 8;
  localparam int              DEPTH    = 3;
  localparam int              LONG_CNT = 100;
  localparam int              REP_CNT  = 20;
  localparam logic [N_CH-1:0] INV      = 8'h08;
  localparam logic [N_CH-1:0] LVL_MASK [2] = '{8'h80, 8'h00};
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic            clk_db;
  logic            rst;
  logic [N_CH-1:0] raw_i;
  logic [N_CH-1:0] keys;
  logic [N_CH-1:0] level_a, press_a, rel_a, long_a, rep_a;
  logic [N_CH-1:0] level_b, press_b, rel_b, long_b, rep_b;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [DEPTH+1:0] hist   [2][N_CH];
  bit               m_lvl  [2][N_CH];
  int               held   [2][N_CH];
  logic [N_CH-1:0]  e_level [2];
  logic [N_CH-1:0]  e_press [2];
  logic [N_CH-1:0]  e_rel   [2];
  logic [N_CH-1:0]  e_long  [2];
  logic [N_CH-1:0]  e_rep   [2];

  logic [10*N_CH-1:0] obs_all;
  logic [10*N_CH-1:0] exp_all;

  assign obs_all = {level_a, press_a, rel_a, long_a, rep_a, level_b, press_b, rel_b, long_b, rep_b};
  assign exp_all = {e_level[0], e_press[0], e_rel[0], e_long[0], e_rep[0],
                    e_level[1], e_press[1], e_rel[1], e_long[1], e_rep[1]};

  key_debounce_multi #(
    .N_CH(N_CH), .DEPTH(DEPTH), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT),
    .LEVEL_MASK(8'h80), .INV_MASK(INV)
  ) dut_a (
    .clk_db(clk_db), .rst(rst), .raw_i(raw_i),
    .level_o(level_a), .press_o(press_a), .rel_o(rel_a), .long_o(long_a), .rep_o(rep_a)
  );

  key_debounce_multi #(
    .N_CH(N_CH), .DEPTH(DEPTH), .LONG_CNT(LONG_CNT), .REP_CNT(REP_CNT),
    .LEVEL_MASK(8'h00), .INV_MASK(INV)
  ) dut_b (
    .clk_db(clk_db), .rst(rst), .raw_i(raw_i),
    .level_o(level_b), .press_o(press_b), .rel_o(rel_b), .long_o(long_b), .rep_o(rep_b)
  );

  initial clk_db = 1'b0;
  always #5 clk_db = ~clk_db;

  // Reference model: level follows samples taken 3..DEPTH+2 edges ago once they all agree;
  // pulses derive from edges of that level and the number of cycles held since the press.
  task automatic model_step();
    logic [DEPTH-1:0] win;
    bit               nl;
    for (int d = 0; d < 2; d++) begin
      e_press[d] = '0;
      e_rel[d]   = '0;
      e_long[d]  = '0;
      e_rep[d]   = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (rst) begin
          hist[d][c]  = '0;
          m_lvl[d][c] = 1'b0;
          held[d][c]  = 0;
        end else begin
          win = hist[d][c][DEPTH+1:2];
          nl  = (&win) ? 1'b1 : ((|win) ? m_lvl[d][c] : 1'b0);
          if (!LVL_MASK[d][c]) begin
            if (nl && !m_lvl[d][c]) begin
              e_press[d][c] = 1'b1;
              held[d][c]    = 0;
            end else if (!nl && m_lvl[d][c]) begin
              e_rel[d][c] = 1'b1;
            end else if (nl) begin
              held[d][c]++;
              if (held[d][c] == LONG_CNT) e_long[d][c] = 1'b1;
              if (AUTO_REP && held[d][c] > LONG_CNT && ((held[d][c] - LONG_CNT) % REP_CNT) == 0)
                e_rep[d][c] = 1'b1;
            end
          end
          m_lvl[d][c] = nl;
          hist[d][c]  = {hist[d][c][DEPTH:0], raw_i[c] ^ INV[c]};
        end
        e_level[d][c] = m_lvl[d][c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_db);
    cyc++;
    model_step();
    @(negedge clk_db);
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] k);
    keys  = k;
    raw_i = k ^ INV;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply_stimulus('0);
    tick();
    tick();
    total++;
    if (obs_all !== '0) $display("[TB] FAIL reset_outputs got=%h want=0", obs_all);
    else passed++;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    for (int t = 0; t < 14; t++) begin
      apply_stimulus((t < 2) ? 8'h01 : 8'h00);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (level_a[0] || press_a[0] || rel_a[0]) seen++;
    end
    total++;
    if (seen !== 0) $display("[TB] FAIL glitch_activity got=%0d want=0", seen);
    else passed++;
  endtask

  task automatic test_press_release();
    int k, pc, rc, np, nr;
    k = cyc + 1; pc = -1; rc = -1; np = 0; nr = 0;
    for (int t = 0; t < 45; t++) begin
      apply_stimulus((t < 30) ? 8'h01 : 8'h00);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL press_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (press_a[0]) begin np++; pc = cyc; end
      if (rel_a[0]) begin nr++; rc = cyc; end
    end
    total++;
    if (pc !== k + 5 || np !== 1) $display("[TB] FAIL press_timing got=%0d/%0d want=%0d/1", pc, np, k + 5);
    else passed++;
    total++;
    if (rc !== k + 35 || nr !== 1) $display("[TB] FAIL rel_timing got=%0d/%0d want=%0d/1", rc, nr, k + 35);
    else passed++;
  endtask

  task automatic test_long();
    int k, pc, lc, fr, nrep;
    k = cyc + 1; pc = -1; lc = -1; fr = -1; nrep = 0;
    for (int t = 0; t < 215; t++) begin
      apply_stimulus((t < 200) ? 8'h02 : 8'h00);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL long_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (press_b[1]) pc = cyc;
      if (long_b[1]) lc = cyc;
      if (rep_b[1]) begin
        nrep++;
        if (fr < 0) fr = cyc;
      end
    end
    total++;
    if (lc !== k + 105 || pc !== k + 5) $display("[TB] FAIL long_timing got=%0d want=%0d", lc, k + 105);
    else passed++;
    total++;
    if (nrep !== (AUTO_REP ? 4 : 0)) $display("[TB] FAIL rep_count got=%0d want=%0d", nrep, AUTO_REP ? 4 : 0);
    else passed++;
    total++;
    if (fr !== (AUTO_REP ? k + 125 : -1)) $display("[TB] FAIL rep_first got=%0d want=%0d", fr, AUTO_REP ? k + 125 : -1);
    else passed++;
  endtask

  task automatic test_level_only();
    int k, rc, fc, np;
    k = cyc + 1; rc = -1; fc = -1; np = 0;
    for (int t = 0; t < 45; t++) begin
      apply_stimulus(((t < 10) || (t >= 20 && t < 30)) ? 8'h80 : 8'h00);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL level_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (level_a[7] && rc < 0) rc = cyc;
      if (!level_a[7] && rc >= 0 && fc < 0) fc = cyc;
      if (press_a[7] || rel_a[7] || long_a[7] || rep_a[7]) np++;
    end
    total++;
    if (rc !== k + 5 || fc !== k + 15) $display("[TB] FAIL level_latency got=%0d,%0d want=%0d,%0d", rc, fc, k + 5, k + 15);
    else passed++;
    total++;
    if (np !== 0) $display("[TB] FAIL level_pulses got=%0d want=0", np);
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    int k, pe, p1, p2, nl;
    k = cyc + 1; pe = k + 5; p1 = -1; p2 = -1; nl = 0;
    apply_stimulus(8'h04);
    for (int t = 0; t < 130; t++) begin
      rst = (cyc + 1 == pe + 50);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL rstmid_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (cyc == pe + 50) begin
        total++;
        if (obs_all !== '0) $display("[TB] FAIL rstmid_zero got=%h want=0", obs_all);
        else passed++;
      end
      if (press_a[2]) begin
        if (p1 < 0) p1 = cyc;
        else p2 = cyc;
      end
      if (long_a[2]) nl++;
    end
    rst = 1'b0;
    total++;
    if (p1 !== pe || p2 !== pe + 56) $display("[TB] FAIL rstmid_repress got=%0d,%0d want=%0d,%0d", p1, p2, pe, pe + 56);
    else passed++;
    total++;
    if (nl !== 0) $display("[TB] FAIL rstmid_long got=%0d want=0", nl);
    else passed++;
    apply_stimulus('0);
    for (int t = 0; t < 12; t++) begin
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL rstmid_settle cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    int k, pc, rc, np, nr, nl;
    logic [N_CH-1:0] pv, rv;
    k = cyc + 1; pc = -1; rc = -1; np = 0; nr = 0; nl = 0; pv = '0; rv = '0;
    for (int t = 0; t < 120; t++) begin
      apply_stimulus((t < 99) ? 8'hFF : 8'h00);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL simul_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
      if (press_b != '0) begin np++; pc = cyc; pv = press_b; end
      if (rel_b != '0) begin nr++; rc = cyc; rv = rel_b; end
      if (long_b != '0) nl++;
    end
    total++;
    if (pv !== 8'hFF || np !== 1 || pc !== k + 5) $display("[TB] FAIL simul_press got=%h@%0d want=ff@%0d", pv, pc, k + 5);
    else passed++;
    total++;
    if (rv !== 8'hFF || nr !== 1 || rc !== k + 104) $display("[TB] FAIL simul_rel got=%h@%0d want=ff@%0d", rv, rc, k + 104);
    else passed++;
    total++;
    if (nl !== 0) $display("[TB] FAIL simul_long got=%0d want=0", nl);
    else passed++;
  endtask

  task automatic test_random();
    int              remain [N_CH];
    logic [N_CH-1:0] k;
    k = '0;
    for (int c = 0; c < N_CH; c++) remain[c] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (remain[c] == 0) begin
          k[c] = ~k[c];
          case ($urandom_range(0, 3))
            0:       remain[c] = int'($urandom_range(1, 4));
            1, 2:    remain[c] = int'($urandom_range(5, 30));
            default: remain[c] = int'($urandom_range(95, 170));
          endcase
        end else begin
          remain[c]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      apply_stimulus(k);
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
    end
    rst = 1'b0;
    apply_stimulus('0);
    for (int t = 0; t < 12; t++) begin
      tick();
      total++;
      if (obs_all !== exp_all) $display("[TB] FAIL random_settle cyc=%0d got=%h want=%h", cyc, obs_all, exp_all);
      else passed++;
    end
  endtask

  // Directed scenarios first, then a long randomized run, then the summary.
  initial begin
    rst = 1'b1;
    apply_stimulus('0);
    test_reset();
    test_glitch();
    test_press_release();
    test_long();
    test_level_only();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
